// File: rtl/vertex_proj_seq.sv
// Per-frame perspective projection sequencer: on each refresh it walks the vertex list and
// projects (x, y) by z with a shared-divisor restoring divider, one quotient bit per cycle.
module vertex_proj_seq #(
    parameter int unsigned INT_BITS    = 7,
    parameter int unsigned SCALE_SHIFT = 0,
    parameter int unsigned NUM_VERTS   = 6,
    parameter int unsigned IDX_BITS    = 3
) (
    input  logic                mclk,
    input  logic                reset,
    input  logic                refresh,
    output logic [IDX_BITS-1:0] vert_idx,
    input  logic [INT_BITS:0]   vert_x,
    input  logic [INT_BITS:0]   vert_y,
    input  logic [INT_BITS:0]   vert_z,
    output logic                wr_en,
    output logic [IDX_BITS-1:0] wr_idx,
    output logic [INT_BITS:0]   wr_px,
    output logic [INT_BITS:0]   wr_py,
    output logic                busy,
    output logic                frame_done,
    output logic                div_zero,
    output logic                overrun
);
    localparam int unsigned W  = INT_BITS + 1;
    localparam int unsigned N  = W + SCALE_SHIFT;
    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_VERTS - 1);

    typedef enum logic [2:0] {StIdle, StFetch, StDiv, StWrite, StDone} state_e;

    state_e              r_state;
    logic [CW-1:0]       r_cnt;
    logic [N-1:0]        r_num_x, r_num_y, r_q_x, r_q_y;
    logic [W-1:0]        r_rem_x, r_rem_y, r_z;
    logic                r_zero;
    logic [IDX_BITS-1:0] r_vert_idx, r_wr_idx;
    logic [W-1:0]        r_wr_px, r_wr_py;
    logic                r_wr_en, r_busy, r_frame_done, r_div_zero, r_overrun;

    logic [W:0]   w_sh_x, w_sh_y, w_z_ext;
    logic         w_ge_x, w_ge_y;
    logic [W-1:0] w_rem_x, w_rem_y;
    logic [N-1:0] w_q_x, w_q_y;

    // One restoring step for both coordinates against the shared divisor.
    always_comb begin
        w_z_ext = {1'b0, r_z};
        w_sh_x  = {r_rem_x, r_num_x[N-1]};
        w_sh_y  = {r_rem_y, r_num_y[N-1]};
        w_ge_x  = (w_sh_x >= w_z_ext);
        w_ge_y  = (w_sh_y >= w_z_ext);
        w_rem_x = w_ge_x ? W'(w_sh_x - w_z_ext) : W'(w_sh_x);
        w_rem_y = w_ge_y ? W'(w_sh_y - w_z_ext) : W'(w_sh_y);
        w_q_x   = (r_q_x << 1) | N'(w_ge_x);
        w_q_y   = (r_q_y << 1) | N'(w_ge_y);
    end

    function automatic logic [W-1:0] sat(input logic [N-1:0] q, input logic zero);
        if (zero || ((q >> W) != '0)) begin
            sat = {W{1'b1}};
        end else begin
            sat = q[W-1:0];
        end
    endfunction

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_num_x      <= '0;
            r_num_y      <= '0;
            r_q_x        <= '0;
            r_q_y        <= '0;
            r_rem_x      <= '0;
            r_rem_y      <= '0;
            r_z          <= '0;
            r_zero       <= 1'b0;
            r_vert_idx   <= '0;
            r_wr_idx     <= '0;
            r_wr_px      <= '0;
            r_wr_py      <= '0;
            r_wr_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_div_zero   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            if (refresh && (r_state != StIdle)) begin
                r_overrun <= 1'b1;
            end
            unique case (r_state)
                StIdle: begin
                    if (refresh) begin
                        r_state    <= StFetch;
                        r_vert_idx <= '0;
                        r_div_zero <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                StFetch: begin
                    r_num_x <= N'(vert_x) << SCALE_SHIFT;
                    r_num_y <= N'(vert_y) << SCALE_SHIFT;
                    r_q_x   <= '0;
                    r_q_y   <= '0;
                    r_rem_x <= '0;
                    r_rem_y <= '0;
                    r_z     <= vert_z;
                    r_zero  <= (vert_z == '0);
                    r_cnt   <= CW'(N);
                    if (vert_z == '0) begin
                        r_div_zero <= 1'b1;
                    end
                    r_state <= StDiv;
                end
                StDiv: begin
                    r_rem_x <= w_rem_x;
                    r_rem_y <= w_rem_y;
                    r_q_x   <= w_q_x;
                    r_q_y   <= w_q_y;
                    r_num_x <= r_num_x << 1;
                    r_num_y <= r_num_y << 1;
                    r_cnt   <= r_cnt - 1'b1;
                    // Final quotient bit is folded straight into the registered write data.
                    if (r_cnt == CW'(1)) begin
                        r_state  <= StWrite;
                        r_wr_en  <= 1'b1;
                        r_wr_idx <= r_vert_idx;
                        r_wr_px  <= sat(w_q_x, r_zero);
                        r_wr_py  <= sat(w_q_y, r_zero);
                    end
                end
                StWrite: begin
                    if (r_vert_idx == LAST_IDX) begin
                        r_state      <= StDone;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_vert_idx <= r_vert_idx + 1'b1;
                        r_state    <= StFetch;
                    end
                end
                StDone: begin
                    r_state    <= StIdle;
                    r_vert_idx <= '0;
                    r_busy     <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign vert_idx   = r_vert_idx;
    assign wr_en      = r_wr_en;
    assign wr_idx     = r_wr_idx;
    assign wr_px      = r_wr_px;
    assign wr_py      = r_wr_py;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign div_zero   = r_div_zero;
    assign overrun    = r_overrun;

endmodule
